// File: rtl/dpram_port_arbiter_pkg.sv
// Shared types and the round-robin pick used by the two-requester RAM port arbiter.
package dpram_port_arbiter_pkg;

    typedef logic req_id_t;

    localparam req_id_t REQ_M0 = 1'b0;
    localparam req_id_t REQ_M1 = 1'b1;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } grant_t;

    // On a tie the requester that did not win last time goes next.
    function automatic grant_t rr_pick(
        input logic    req0,
        input logic    req1,
        input req_id_t last_grant
    );
        grant_t g;
        g.valid = req0 | req1;
        if (req0 && req1) begin
            g.id = ~last_grant;
        end else if (req1) begin
            g.id = REQ_M1;
        end else begin
            g.id = REQ_M0;
        end
        return g;
    endfunction

endpackage

// File: rtl/dpram_port_arbiter.sv
// Arbitrates two requesters onto the single core-side port of the dual-port RAM,
// with round-robin fairness, bounded lock bursts and one-cycle read return routing.
module dpram_port_arbiter
    import dpram_port_arbiter_pkg::*;
#(
    parameter int ByteLength = 8,
    parameter int AddrWidth  = 32,
    parameter int DataWidth  = 32,
    parameter int MaxLock    = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,

    input  logic [AddrWidth-1:0]            m0_addr_i,
    input  logic                            m0_wren_i,
    input  logic                            m0_rden_i,
    input  logic [DataWidth-1:0]            m0_wdata_i,
    input  logic [DataWidth/ByteLength-1:0] m0_wmask_i,
    input  logic                            m0_lock_i,
    output logic                            m0_hit_o,
    output logic [DataWidth-1:0]            m0_rdata_o,
    output logic                            m0_rvalid_o,

    input  logic [AddrWidth-1:0]            m1_addr_i,
    input  logic                            m1_wren_i,
    input  logic                            m1_rden_i,
    input  logic [DataWidth-1:0]            m1_wdata_i,
    input  logic [DataWidth/ByteLength-1:0] m1_wmask_i,
    input  logic                            m1_lock_i,
    output logic                            m1_hit_o,
    output logic [DataWidth-1:0]            m1_rdata_o,
    output logic                            m1_rvalid_o,

    output logic [AddrWidth-1:0]            mem_addr_o,
    output logic                            mem_wren_o,
    output logic [DataWidth-1:0]            mem_wdata_o,
    output logic [DataWidth/ByteLength-1:0] mem_wmask_o,
    output logic                            mem_rden_o,
    input  logic [DataWidth-1:0]            mem_rdata_i
);

    localparam int CntWidth = $clog2(MaxLock + 1);
    localparam logic [CntWidth-1:0] LockLimit  = CntWidth'(MaxLock);
    localparam bit                  LockEnable = (MaxLock > 1);

    localparam logic [0:0] ST_OPEN = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]          state_q, state_d;
    req_id_t             lock_owner_q, lock_owner_d;
    logic [CntWidth-1:0] lock_cnt_q, lock_cnt_d, lock_cnt_inc;
    req_id_t             last_grant_q, last_grant_d;
    logic                rd_valid_q;
    req_id_t             rd_owner_q;

    logic [1:0] req;
    logic [1:0] lock;
    logic       owner_hold;
    grant_t     rr;
    logic       grant_valid;
    req_id_t    grant_id;

    // Grant decision; reset forces no grant so nothing reaches the RAM.
    always_comb begin
        req         = {m1_rden_i | m1_wren_i, m0_rden_i | m0_wren_i};
        lock        = {m1_lock_i, m0_lock_i};
        owner_hold  = (state_q == ST_LOCK) && req[lock_owner_q] && lock[lock_owner_q];
        rr          = rr_pick(req[0], req[1], last_grant_q);
        grant_valid = 1'b0;
        grant_id    = REQ_M0;
        if (!rst_i) begin
            if (owner_hold) begin
                grant_valid = 1'b1;
                grant_id    = lock_owner_q;
            end else begin
                grant_valid = rr.valid;
                grant_id    = rr.id;
            end
        end
    end

    // A lost owner-hold falls straight back to arbitration in the same cycle,
    // so a fresh lock can be taken without an idle OPEN cycle in between.
    always_comb begin
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        last_grant_d = last_grant_q;
        lock_cnt_inc = lock_cnt_q + CntWidth'(1);
        if (grant_valid) begin
            last_grant_d = grant_id;
            if (owner_hold) begin
                if (lock_cnt_inc == LockLimit) begin
                    state_d    = ST_OPEN;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_inc;
                end
            end else if (lock[grant_id] && LockEnable) begin
                state_d      = ST_LOCK;
                lock_owner_d = grant_id;
                lock_cnt_d   = CntWidth'(1);
            end else begin
                state_d    = ST_OPEN;
                lock_cnt_d = '0;
            end
        end else begin
            state_d    = ST_OPEN;
            lock_cnt_d = '0;
        end
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_wren_o  = 1'b0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        mem_rden_o  = 1'b0;
        if (grant_valid) begin
            if (grant_id == REQ_M1) begin
                mem_addr_o  = m1_addr_i;
                mem_wren_o  = m1_wren_i;
                mem_wdata_o = m1_wdata_i;
                mem_wmask_o = m1_wmask_i;
                mem_rden_o  = m1_rden_i;
            end else begin
                mem_addr_o  = m0_addr_i;
                mem_wren_o  = m0_wren_i;
                mem_wdata_o = m0_wdata_i;
                mem_wmask_o = m0_wmask_i;
                mem_rden_o  = m0_rden_i;
            end
        end
    end

    assign m0_hit_o = grant_valid && (grant_id == REQ_M0);
    assign m1_hit_o = grant_valid && (grant_id == REQ_M1);

    // Read return is also gated by rst_i so a read in flight at reset stays silent.
    assign m0_rvalid_o = rd_valid_q && !rst_i && (rd_owner_q == REQ_M0);
    assign m1_rvalid_o = rd_valid_q && !rst_i && (rd_owner_q == REQ_M1);
    assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_OPEN;
            lock_owner_q <= REQ_M0;
            lock_cnt_q   <= '0;
            last_grant_q <= REQ_M1;
            rd_valid_q   <= 1'b0;
            rd_owner_q   <= REQ_M0;
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            last_grant_q <= last_grant_d;
            rd_valid_q   <= grant_valid && mem_rden_o;
            rd_owner_q   <= grant_id;
        end
    end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: directed vector table for the corner cases, then
// random traffic checked against a rule-level model of arbitration and RAM contents.
module tb_dpram_port_arbiter;

    localparam int MaxLock = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic        m0_wren_i, m0_rden_i, m0_lock_i, m1_wren_i, m1_rden_i, m1_lock_i;
    logic [31:0] m0_wdata_i, m1_wdata_i;
    logic [3:0]  m0_wmask_i, m1_wmask_i;
    logic        m0_hit_o, m1_hit_o, m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_wren_o, mem_rden_o;
    logic [3:0]  mem_wmask_o;
    logic [31:0] mem_rdata_i = '0;

    always #5 clk_i = ~clk_i;

    dpram_port_arbiter #(
        .ByteLength(8),
        .AddrWidth (32),
        .DataWidth (32),
        .MaxLock   (MaxLock)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .m0_addr_i  (m0_addr_i),
        .m0_wren_i  (m0_wren_i),
        .m0_rden_i  (m0_rden_i),
        .m0_wdata_i (m0_wdata_i),
        .m0_wmask_i (m0_wmask_i),
        .m0_lock_i  (m0_lock_i),
        .m0_hit_o   (m0_hit_o),
        .m0_rdata_o (m0_rdata_o),
        .m0_rvalid_o(m0_rvalid_o),
        .m1_addr_i  (m1_addr_i),
        .m1_wren_i  (m1_wren_i),
        .m1_rden_i  (m1_rden_i),
        .m1_wdata_i (m1_wdata_i),
        .m1_wmask_i (m1_wmask_i),
        .m1_lock_i  (m1_lock_i),
        .m1_hit_o   (m1_hit_o),
        .m1_rdata_o (m1_rdata_o),
        .m1_rvalid_o(m1_rvalid_o),
        .mem_addr_o (mem_addr_o),
        .mem_wren_o (mem_wren_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_wmask_o(mem_wmask_o),
        .mem_rden_o (mem_rden_o),
        .mem_rdata_i(mem_rdata_i)
    );

    function automatic logic [31:0] init_word(input int i);
        return {8'(i), 8'(~i), 8'(i * 3), 8'hC3};
    endfunction

    // RAM behind the arbiter: one-cycle read latency, read returns pre-write data.
    logic [31:0] ram [256];
    logic        ram_load = 1'b1;
    always @(posedge clk_i) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else begin
            if (mem_rden_o) mem_rdata_i <= ram[mem_addr_o[9:2]];
            if (mem_wren_o)
                for (int b = 0; b < 4; b++)
                    if (mem_wmask_o[b]) ram[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who holds a lock burst and how long it has run, who won last,
    // which requester expects read data next cycle, and a shadow copy of the RAM.
    int          m_last = 1, m_owner = -1, m_streak = 0, m_rd_who = -1, m_win = -1;
    logic [31:0] m_rd_data = '0;
    logic [31:0] shadow [256];

    task automatic model_cycle();
        logic [1:0]  req, lk;
        logic [31:0] ea, ewd;
        logic [3:0]  ewm;
        logic        ewr, erd;
        int          win;
        bit          held;
        req  = {m1_rden_i | m1_wren_i, m0_rden_i | m0_wren_i};
        lk   = {m1_lock_i, m0_lock_i};
        win  = -1;
        held = 0;
        if (!rst_i) begin
            if (m_owner >= 0 && req[m_owner] && lk[m_owner]) begin
                win  = m_owner;
                held = 1;
            end else if (req == 2'b11) win = 1 - m_last;
            else if (req[0]) win = 0;
            else if (req[1]) win = 1;
        end
        {ea, ewd, ewm, ewr, erd} = '0;
        if (win == 0) {ea, ewd, ewm, ewr, erd} = {m0_addr_i, m0_wdata_i, m0_wmask_i, m0_wren_i, m0_rden_i};
        if (win == 1) {ea, ewd, ewm, ewr, erd} = {m1_addr_i, m1_wdata_i, m1_wmask_i, m1_wren_i, m1_rden_i};

        chk("hit0", m0_hit_o, win == 0);
        chk("hit1", m1_hit_o, win == 1);
        chk("mem_addr", mem_addr_o, ea);
        chk("mem_wren_rden", {mem_wren_o, mem_rden_o}, {ewr, erd});
        chk("mem_wdata", mem_wdata_o, ewd);
        chk("mem_wmask", mem_wmask_o, ewm);
        chk("rvalid0", m0_rvalid_o, !rst_i && m_rd_who == 0);
        chk("rvalid1", m1_rvalid_o, !rst_i && m_rd_who == 1);
        chk("rdata0", m0_rdata_o, (!rst_i && m_rd_who == 0) ? m_rd_data : 32'h0);
        chk("rdata1", m1_rdata_o, (!rst_i && m_rd_who == 1) ? m_rd_data : 32'h0);

        if (rst_i) begin
            m_last = 1; m_owner = -1; m_streak = 0; m_rd_who = -1;
        end else begin
            m_rd_who = -1;
            if (win >= 0) begin
                if (erd) begin
                    m_rd_who  = win;
                    m_rd_data = shadow[ea[9:2]];
                end
                if (ewr)
                    for (int b = 0; b < 4; b++)
                        if (ewm[b]) shadow[ea[9:2]][8*b +: 8] = ewd[8*b +: 8];
                m_last = win;
                if (held) begin
                    m_streak++;
                    if (m_streak == MaxLock) begin
                        m_owner  = -1;
                        m_streak = 0;
                    end
                end else if (lk[win] && MaxLock > 1) begin
                    m_owner  = win;
                    m_streak = 1;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_owner = -1;
            end
        end
        m_win = win;
    endtask

    task automatic apply(input logic rst, input logic [2:0] c0, input logic [31:0] a0,
                         input logic [31:0] wd0, input logic [3:0] wm0,
                         input logic [2:0] c1, input logic [31:0] a1,
                         input logic [31:0] wd1, input logic [3:0] wm1);
        rst_i = rst;
        {m0_lock_i, m0_wren_i, m0_rden_i} = c0;
        {m1_lock_i, m1_wren_i, m1_rden_i} = c1;
        m0_addr_i = a0; m0_wdata_i = wd0; m0_wmask_i = wm0;
        m1_addr_i = a1; m1_wdata_i = wd1; m1_wmask_i = wm1;
    endtask

    // Control fields are {lock, wren, rden}; hit and rv are {m1, m0}.
    typedef struct {
        logic        rst;
        logic [2:0]  c0;
        logic [31:0] a0;
        logic [2:0]  c1;
        logic [31:0] a1;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic [1:0]  hit;
        logic [1:0]  rv;
        logic        chk_rd0;
        logic [31:0] rd0;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [2:0] c0, input logic [31:0] a0,
                                input logic [2:0] c1, input logic [31:0] a1,
                                input logic [1:0] hit, input logic [1:0] rv);
        vec_t v;
        v.rst = rst; v.c0 = c0; v.a0 = a0; v.c1 = c1; v.a1 = a1;
        v.wd = '0; v.wm = '0; v.hit = hit; v.rv = rv; v.chk_rd0 = 1'b0; v.rd0 = '0;
        return v;
    endfunction

    localparam int NV = 29;
    vec_t vec [NV];

    bit          pv  [2];
    logic [2:0]  pc  [2];
    logic [31:0] pa  [2], pwd [2];
    logic [3:0]  pwm [2];

    initial begin
        logic [31:0] old40;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        old40 = init_word(16);

        vec[0]  = mk(1, 3'b001, 32'h10, 3'b001, 32'h20, 2'b00, 2'b00);
        vec[1]  = mk(1, 3'b001, 32'h10, 3'b001, 32'h20, 2'b00, 2'b00);
        vec[2]  = mk(0, 3'b001, 32'h10, 3'b001, 32'h20, 2'b01, 2'b00);
        vec[3]  = mk(0, 3'b000, 32'h00, 3'b001, 32'h20, 2'b10, 2'b01);
        vec[4]  = mk(0, 3'b000, 32'h00, 3'b000, 32'h00, 2'b00, 2'b10);
        vec[5]  = mk(0, 3'b101, 32'h00, 3'b001, 32'h04, 2'b01, 2'b00);
        vec[6]  = mk(0, 3'b101, 32'h08, 3'b001, 32'h04, 2'b01, 2'b01);
        vec[7]  = mk(0, 3'b101, 32'h0C, 3'b001, 32'h04, 2'b01, 2'b01);
        vec[8]  = mk(0, 3'b101, 32'h10, 3'b001, 32'h04, 2'b01, 2'b01);
        vec[9]  = mk(0, 3'b101, 32'h14, 3'b001, 32'h04, 2'b10, 2'b01);
        vec[10] = mk(0, 3'b001, 32'h14, 3'b001, 32'h18, 2'b01, 2'b10);
        vec[11] = mk(0, 3'b001, 32'h1C, 3'b001, 32'h18, 2'b10, 2'b01);
        vec[12] = mk(0, 3'b001, 32'h1C, 3'b001, 32'h24, 2'b01, 2'b10);
        vec[13] = mk(0, 3'b000, 32'h00, 3'b000, 32'h00, 2'b00, 2'b01);
        vec[14] = mk(0, 3'b101, 32'h28, 3'b000, 32'h00, 2'b01, 2'b00);
        vec[15] = mk(0, 3'b101, 32'h2C, 3'b001, 32'h30, 2'b01, 2'b01);
        vec[16] = mk(0, 3'b001, 32'h34, 3'b001, 32'h30, 2'b10, 2'b01);
        vec[17] = mk(0, 3'b000, 32'h00, 3'b000, 32'h00, 2'b00, 2'b10);
        vec[18] = mk(0, 3'b000, 32'h00, 3'b010, 32'h40, 2'b10, 2'b00);
        vec[18].wd = 32'hDEADBEEF;
        vec[18].wm = 4'b0011;
        vec[19] = mk(0, 3'b001, 32'h40, 3'b000, 32'h00, 2'b01, 2'b00);
        vec[20] = mk(0, 3'b000, 32'h00, 3'b000, 32'h00, 2'b00, 2'b01);
        vec[20].chk_rd0 = 1'b1;
        vec[20].rd0     = {old40[31:16], 16'hBEEF};
        vec[21] = mk(0, 3'b001, 32'h44, 3'b000, 32'h00, 2'b01, 2'b00);
        vec[22] = mk(1, 3'b000, 32'h00, 3'b000, 32'h00, 2'b00, 2'b00);
        vec[23] = mk(0, 3'b000, 32'h00, 3'b000, 32'h00, 2'b00, 2'b00);
        vec[24] = mk(0, 3'b001, 32'h48, 3'b001, 32'h4C, 2'b01, 2'b00);
        vec[25] = mk(0, 3'b000, 32'h00, 3'b001, 32'h4C, 2'b10, 2'b01);
        vec[26] = mk(0, 3'b000, 32'h00, 3'b000, 32'h00, 2'b00, 2'b10);
        vec[27] = mk(0, 3'b011, 32'h80, 3'b000, 32'h00, 2'b01, 2'b00);
        vec[27].wd = 32'h12345678;
        vec[27].wm = 4'b1111;
        vec[28] = mk(0, 3'b000, 32'h00, 3'b000, 32'h00, 2'b00, 2'b01);

        apply(1, '0, '0, '0, '0, '0, '0, '0, '0);
        @(posedge clk_i); #1;
        ram_load = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply(vec[i].rst, vec[i].c0, vec[i].a0, vec[i].wd, vec[i].wm,
                  vec[i].c1, vec[i].a1, vec[i].wd, vec[i].wm);
            @(negedge clk_i);
            chk($sformatf("vec%0d_hit", i), {m1_hit_o, m0_hit_o}, vec[i].hit);
            chk($sformatf("vec%0d_rvalid", i), {m1_rvalid_o, m0_rvalid_o}, vec[i].rv);
            if (vec[i].chk_rd0) chk($sformatf("vec%0d_rdata0", i), m0_rdata_o, vec[i].rd0);
            model_cycle();
            @(posedge clk_i); #1;
        end

        // Random traffic: each requester holds its request until the model grants it.
        pv[0] = 0; pv[1] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic r;
            r = ($urandom_range(0, 199) == 0);
            for (int n = 0; n < 2; n++) begin
                if (!pv[n] && $urandom_range(0, 9) < 6) begin
                    logic [1:0] op;
                    op     = 2'($urandom_range(1, 3));
                    pv[n]  = 1;
                    pc[n]  = {($urandom_range(0, 2) == 0), op};
                    pa[n]  = {22'd0, 8'($urandom), 2'b00};
                    pwd[n] = $urandom;
                    pwm[n] = 4'($urandom);
                end
            end
            apply(r, pv[0] ? pc[0] : 3'b000, pv[0] ? pa[0] : 32'h0, pv[0] ? pwd[0] : 32'h0, pv[0] ? pwm[0] : 4'h0,
                     pv[1] ? pc[1] : 3'b000, pv[1] ? pa[1] : 32'h0, pv[1] ? pwd[1] : 32'h0, pv[1] ? pwm[1] : 4'h0);
            @(negedge clk_i);
            model_cycle();
            if (m_win >= 0) pv[m_win] = 0;
            @(posedge clk_i); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
